// File: rtl/tdes_sequencer.sv
// Triple-DES (EDE) sequencer: runs one single-DES core three times per block,
// selecting key and direction for each pass and chaining every pass result
// into the next pass input. Returns the final block with a one-cycle done.
module tdes_sequencer #(
    parameter int RST_CYCLES = 2,   // core reset cycles at the start of each pass (>= 1)
    parameter int OUT_LAT    = 1,   // cycles from des_done to valid des_data_out
    parameter int TIMEOUT    = 64   // max cycles waiting for des_done per pass
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        mode,
    input  logic [63:0] data_in,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic [63:0] data_out,
    output logic        done,
    output logic        busy,
    output logic        error,
    output logic        des_reset,
    output logic [63:0] des_data_in,
    output logic [63:0] des_key,
    output logic        des_decrypt,
    input  logic [63:0] des_data_out,
    input  logic        des_done
);

    // One shared counter covers reset hold, timeout and output settle.
    localparam int CNT_MAX = (TIMEOUT > RST_CYCLES)
                           ? ((TIMEOUT > OUT_LAT) ? TIMEOUT : OUT_LAT)
                           : ((RST_CYCLES > OUT_LAT) ? RST_CYCLES : OUT_LAT);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] OUT_LAST = CW'((OUT_LAT > 0) ? OUT_LAT - 1 : 0);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_SETTLE,
        S_FINISH,
        S_ABORT
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [1:0]    pass_idx;
    logic          mode_q;
    logic [63:0]   k1_q, k2_q, k3_q;

    logic accept, capture, timeout_hit, cnt_clr, cnt_inc;

    // Key for a pass: encrypt runs K1,K2,K3; decrypt runs K3,K2,K1.
    function automatic logic [63:0] sched_key(input logic [1:0] p, input logic m,
                                              input logic [63:0] a, input logic [63:0] b,
                                              input logic [63:0] c);
        logic [63:0] k;
        case (p)
            2'd0:    k = m ? c : a;
            2'd1:    k = b;
            default: k = m ? a : c;
        endcase
        return k;
    endfunction

    // Direction for a pass: EDE, so the middle pass runs opposite to the mode.
    function automatic logic sched_dec(input logic [1:0] p, input logic m);
        return m ^ (p == 2'd1);
    endfunction

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state logic and per-state control outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_next  = state;
        accept      = 1'b0;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        done        = 1'b0;
        busy        = 1'b0;
        des_reset   = 1'b1;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                busy = 1'b1;
                if (cnt == RST_LAST) begin
                    cnt_clr    = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_WAIT: begin
                busy      = 1'b1;
                des_reset = 1'b0;
                if (des_done) begin
                    cnt_clr = 1'b1;
                    if (OUT_LAT == 0) capture    = 1'b1;
                    else              state_next = S_SETTLE;
                end else if (cnt == TO_LAST) begin
                    cnt_clr     = 1'b1;
                    timeout_hit = 1'b1;
                    state_next  = S_ABORT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_SETTLE: begin
                busy      = 1'b1;
                des_reset = 1'b0;
                if (cnt == OUT_LAST) begin
                    cnt_clr = 1'b1;
                    capture = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            S_FINISH: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            S_ABORT: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        if (capture) state_next = (pass_idx == 2'd2) ? S_FINISH : S_LOAD;
    end

    // Operand latch, pass chaining and result/error registers.
    // des_data_in doubles as the chain register between passes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state registers here use <= so every read sees the pre-edge value.
            mode_q      <= 1'b0;
            k1_q        <= '0;
            k2_q        <= '0;
            k3_q        <= '0;
            pass_idx    <= '0;
            cnt         <= '0;
            data_out    <= '0;
            error       <= 1'b0;
            des_data_in <= '0;
            des_key     <= '0;
            des_decrypt <= 1'b0;
        end else begin
            if (cnt_clr)      cnt <= '0;
            else if (cnt_inc) cnt <= cnt + 1'b1;

            if (accept) begin
                mode_q      <= mode;
                k1_q        <= key1;
                k2_q        <= key2;
                k3_q        <= key3;
                pass_idx    <= 2'd0;
                error       <= 1'b0;
                des_data_in <= data_in;
                des_key     <= sched_key(2'd0, mode, key1, key2, key3);
                des_decrypt <= sched_dec(2'd0, mode);
            end

            if (capture) begin
                if (pass_idx == 2'd2) begin
                    data_out <= des_data_out;
                end else begin
                    pass_idx    <= pass_idx + 2'd1;
                    des_data_in <= des_data_out;
                    des_key     <= sched_key(pass_idx + 2'd1, mode_q, k1_q, k2_q, k3_q);
                    des_decrypt <= sched_dec(pass_idx + 2'd1, mode_q);
                end
            end

            if (timeout_hit) error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tdes_sequencer.sv
// Directed self-checking bench for tdes_sequencer with a behavioural DES core
// model that has a fixed done delay and logs (key, direction, input) per pass.
module tb_tdes_sequencer;

    localparam logic [63:0] K_STD = 64'h133457799BBCDFF1;
    localparam logic [63:0] PT    = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT    = 64'h85E813540F0AB405;
    localparam logic [63:0] K1    = 64'h1111111111111111;
    localparam logic [63:0] K2    = 64'h2222222222222222;
    localparam logic [63:0] K3    = 64'h3333333333333333;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [63:0] data_in, key1, key2, key3;
    logic [63:0] data_out;
    logic        done, busy, error;
    logic        des_reset, des_decrypt;
    logic [63:0] des_data_in, des_key, des_data_out;
    logic        des_done;

    int checks = 0;
    int errors = 0;

    tdes_sequencer #(.RST_CYCLES(2), .OUT_LAT(1), .TIMEOUT(64)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .mode         (mode),
        .data_in      (data_in),
        .key1         (key1),
        .key2         (key2),
        .key3         (key3),
        .data_out     (data_out),
        .done         (done),
        .busy         (busy),
        .error        (error),
        .des_reset    (des_reset),
        .des_data_in  (des_data_in),
        .des_key      (des_key),
        .des_decrypt  (des_decrypt),
        .des_data_out (des_data_out),
        .des_done     (des_done)
    );

    always #5 clk = ~clk;

    // Core model: known-answer for the standard DES vector, cheap keyed mix otherwise.
    function automatic logic [63:0] des_model(input logic [63:0] k, input logic dec,
                                              input logic [63:0] d);
        if (k == K_STD && !dec && d == PT) return CT;
        if (k == K_STD &&  dec && d == CT) return PT;
        return {d[62:0], d[63]} ^ k ^ {64{dec}};
    endfunction

    typedef struct {
        logic [63:0] key;
        logic        dec;
        logic [63:0] din;
    } pass_rec_t;

    pass_rec_t   log_q[$];
    int          core_delay = 5;
    logic        hang       = 1'b0;
    int          core_cnt   = 0;
    logic        core_done  = 1'b0;
    logic [63:0] core_out   = 64'hBADBADBADBADBAD0;
    int          done_seen  = 0;

    assign des_done     = core_done;
    assign des_data_out = core_out;

    // Core behaviour: done rises core_delay edges after reset falls; data one edge later.
    always @(posedge clk) begin
        if (des_reset) begin
            core_cnt  <= 0;
            core_done <= 1'b0;
        end else begin
            core_cnt <= core_cnt + 1;
            if (!hang && core_cnt + 1 == core_delay) core_done <= 1'b1;
            if (!hang && core_cnt + 1 == core_delay + 1) begin
                core_out <= des_model(des_key, des_decrypt, des_data_in);
                log_q.push_back('{key: des_key, dec: des_decrypt, din: des_data_in});
            end
        end
    end

    // Count every done pulse seen mid-cycle.
    always @(negedge clk) if (done === 1'b1) done_seen <= done_seen + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag, input int idx, input logic [63:0] k,
                             input logic dec, input logic [63:0] din);
        pass_rec_t r;
        r = '{key: 64'hX, dec: 1'bX, din: 64'hX};
        if (idx < log_q.size()) r = log_q[idx];
        check({tag, "_key"}, r.key, k);
        check({tag, "_dec"}, {63'd0, r.dec}, {63'd0, dec});
        check({tag, "_din"}, r.din, din);
    endtask

    // Launch one operation and wait (bounded) for done; cycle 1 is the first after the start edge.
    task automatic run_op(input logic m, input logic [63:0] d, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] c, input logic perturb,
                          output int cyc, output logic got, output logic err1,
                          output logic busy1);
        log_q.delete();
        @(negedge clk);
        mode = m; data_in = d; key1 = a; key2 = b; key3 = c; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        got   = 1'b0;
        err1  = error;
        busy1 = busy;
        while (cyc < 300) begin
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
            if (perturb && cyc == 3) begin
                data_in = ~data_in;
                key1    = ~key1;
                mode    = ~mode;
            end
            if (perturb && cyc == 10) start = 1'b1;
            if (perturb && cyc == 11) start = 1'b0;
            @(negedge clk);
            cyc++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        logic        got, err1, busy1;
        logic [63:0] e0, e1, e2, prev;

        reset = 1'b1; start = 1'b0; mode = 1'b0;
        data_in = '0; key1 = '0; key2 = '0; key3 = '0;
        #2;
        check("rst_data_out", data_out, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_des_reset", {63'd0, des_reset}, 64'd1);
        check("rst_des_data_in", des_data_in, 64'd0);
        check("rst_des_key", des_key, 64'd0);
        check("rst_des_decrypt", {63'd0, des_decrypt}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Standard vector, encrypt, with input changes and a stray start mid-flight.
        run_op(1'b0, PT, K_STD, K_STD, K_STD, 1'b1, cyc, got, err1, busy1);
        check("enc_got_done", {63'd0, got}, 64'd1);
        check("enc_latency", 64'(cyc), 64'd28);
        check("enc_busy_c1", {63'd0, busy1}, 64'd1);
        check("enc_data_out", data_out, CT);
        check("enc_error", {63'd0, error}, 64'd0);
        check("enc_busy_at_done", {63'd0, busy}, 64'd0);
        check("enc_log_size", 64'(log_q.size()), 64'd3);
        check_log("enc_p0", 0, K_STD, 1'b0, PT);
        check_log("enc_p1", 1, K_STD, 1'b1, CT);
        check_log("enc_p2", 2, K_STD, 1'b0, PT);
        @(negedge clk);
        check("enc_done_one_cycle", {63'd0, done}, 64'd0);
        check("enc_idle_after", {63'd0, busy}, 64'd0);

        // Standard vector, decrypt.
        run_op(1'b1, CT, K_STD, K_STD, K_STD, 1'b0, cyc, got, err1, busy1);
        check("dec_got_done", {63'd0, got}, 64'd1);
        check("dec_data_out", data_out, PT);
        check("dec_error", {63'd0, error}, 64'd0);
        check_log("dec_p0", 0, K_STD, 1'b1, CT);
        check_log("dec_p1", 1, K_STD, 1'b0, PT);
        check_log("dec_p2", 2, K_STD, 1'b1, CT);

        // Distinct keys, encrypt: order K1/0, K2/1, K3/0 with chained data.
        e0 = des_model(K1, 1'b0, 64'hA5A50F0F12345678);
        e1 = des_model(K2, 1'b1, e0);
        e2 = des_model(K3, 1'b0, e1);
        run_op(1'b0, 64'hA5A50F0F12345678, K1, K2, K3, 1'b0, cyc, got, err1, busy1);
        check("denc_data_out", data_out, e2);
        check_log("denc_p0", 0, K1, 1'b0, 64'hA5A50F0F12345678);
        check_log("denc_p1", 1, K2, 1'b1, e0);
        check_log("denc_p2", 2, K3, 1'b0, e1);

        // Distinct keys, decrypt: order K3/1, K2/0, K1/1.
        e0 = des_model(K3, 1'b1, 64'h0F1E2D3C4B5A6978);
        e1 = des_model(K2, 1'b0, e0);
        e2 = des_model(K1, 1'b1, e1);
        run_op(1'b1, 64'h0F1E2D3C4B5A6978, K1, K2, K3, 1'b0, cyc, got, err1, busy1);
        check("ddec_data_out", data_out, e2);
        check_log("ddec_p0", 0, K3, 1'b1, 64'h0F1E2D3C4B5A6978);
        check_log("ddec_p1", 1, K2, 1'b0, e0);
        check_log("ddec_p2", 2, K1, 1'b1, e1);
        prev = e2;

        // Core that never completes: timeout pulse with error, result held.
        hang = 1'b1;
        run_op(1'b0, PT, K_STD, K_STD, K_STD, 1'b0, cyc, got, err1, busy1);
        check("to_got_done", {63'd0, got}, 64'd1);
        check("to_error", {63'd0, error}, 64'd1);
        check("to_data_out_held", data_out, prev);
        check("to_busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("to_done_one_cycle", {63'd0, done}, 64'd0);
        check("to_error_held", {63'd0, error}, 64'd1);
        hang = 1'b0;

        // Next start clears error and completes normally.
        run_op(1'b0, PT, K_STD, K_STD, K_STD, 1'b0, cyc, got, err1, busy1);
        check("rec_error_cleared_c1", {63'd0, err1}, 64'd0);
        check("rec_data_out", data_out, CT);
        check("rec_error", {63'd0, error}, 64'd0);

        // Reset asserted at cycle 12 of an operation.
        @(negedge clk);
        mode = 1'b0; data_in = 64'h1122334455667788; key1 = K1; key2 = K2; key3 = K3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        check("mid_busy_before_rst", {63'd0, busy}, 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_data_out", data_out, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_des_reset", {63'd0, des_reset}, 64'd1);
        check("mid_rst_des_key", des_key, 64'd0);
        e0 = 64'(done_seen);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_no_done_pulse", 64'(done_seen), e0);

        run_op(1'b1, CT, K_STD, K_STD, K_STD, 1'b0, cyc, got, err1, busy1);
        check("post_rst_got_done", {63'd0, got}, 64'd1);
        check("post_rst_latency", 64'(cyc), 64'd28);
        check("post_rst_data_out", data_out, PT);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
